// File: rtl/isa_retire_checker.sv
// isa_retire_checker: runtime retirement monitor for the RV32 Fibonacci core.
// It keeps a private shadow register file that follows the core's writes.
// It recomputes ADD/SUB/ADDI/BEQ/BNE/JAL results from that shadow state and
// compares them against the retire stream. The first error is captured and
// errors are counted.
// Optional feature: define ISA_RETIRE_CHK_COVER_EN to build the sticky
// instruction-class coverage bits on cov_seen. Otherwise cov_seen is tied to 0.
module isa_retire_checker #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              chk_en,
  input  logic              err_clr,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [31:0]       retire_instr,
  input  logic [XLEN-1:0]   retire_next_pc,
  input  logic              rf_we,
  input  logic [4:0]        rf_waddr,
  input  logic [XLEN-1:0]   rf_wdata,
  output logic              chk_active,
  output logic              chk_error,
  output logic [2:0]        err_code,
  output logic [XLEN-1:0]   err_pc,
  output logic [31:0]       err_instr,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  retired_count,
  output logic [4:0]        cov_seen
);

  localparam int        AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_HALT = 2'd2} state_t;

  state_t state_q, state_d;
  logic   chk_active_q;

  logic [XLEN-1:0] shadow_q [NREGS];
  logic [XLEN-1:0] shadow_d [NREGS];

  logic              chk_error_q, chk_error_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [XLEN-1:0]   err_pc_q, err_pc_d;
  logic [31:0]       err_instr_q, err_instr_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  retired_count_q, retired_count_d;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_add, is_sub, is_addi, is_beq, is_bne, is_jal;

  // Checker datapath
  logic [XLEN-1:0] imm_i, imm_b, imm_j;
  logic [XLEN-1:0] rs1_v, rs2_v, pc_plus4;
  logic [XLEN-1:0] exp_wdata, exp_npc;
  logic            exp_wr, exp_we, core_we, idx_bad, is_chk;
  logic            wd_mis, wr_mis, npc_mis, in_check, do_chk, err_hit;
  logic [2:0]      code_now;

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // An architectural index beyond the configured register count.
  function automatic logic idx_oob(input logic [4:0] idx);
    return ({1'b0, idx} >= NREGS_L);
  endfunction

  // Shadow read with x0 hard-wired to zero.
  function automatic logic [XLEN-1:0] shadow_rd(input logic [4:0] idx,
                                                input logic [XLEN-1:0] file [NREGS]);
    if (idx == 5'd0 || idx_oob(idx)) return '0;
    return file[idx[AW-1:0]];
  endfunction

  assign opcode = retire_instr[6:0];
  assign rd     = retire_instr[11:7];
  assign funct3 = retire_instr[14:12];
  assign rs1    = retire_instr[19:15];
  assign rs2    = retire_instr[24:20];
  assign funct7 = retire_instr[31:25];

  assign is_add  = (opcode == 7'h33) && (funct3 == 3'd0) && (funct7 == 7'h00);
  assign is_sub  = (opcode == 7'h33) && (funct3 == 3'd0) && (funct7 == 7'h20);
  assign is_addi = (opcode == 7'h13) && (funct3 == 3'd0);
  assign is_beq  = (opcode == 7'h63) && (funct3 == 3'd0);
  assign is_bne  = (opcode == 7'h63) && (funct3 == 3'd1);
  assign is_jal  = (opcode == 7'h6f);

  assign imm_i = {{(XLEN-12){retire_instr[31]}}, retire_instr[31:20]};
  assign imm_b = {{(XLEN-13){retire_instr[31]}}, retire_instr[31], retire_instr[7],
                  retire_instr[30:25], retire_instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){retire_instr[31]}}, retire_instr[31], retire_instr[19:12],
                  retire_instr[20], retire_instr[30:21], 1'b0};

  assign rs1_v    = shadow_rd(rs1, shadow_q);
  assign rs2_v    = shadow_rd(rs2, shadow_q);
  assign pc_plus4 = retire_pc + XLEN'(4);
  assign in_check = (state_q == S_CHECK);

  // Architectural expectation and error classification for the retiring instruction
  always_comb begin
    exp_wdata = '0;
    exp_npc   = pc_plus4;
    exp_wr    = 1'b0;
    idx_bad   = 1'b0;
    is_chk    = 1'b1;
    if (is_add || is_sub) begin
      exp_wdata = is_sub ? (rs1_v - rs2_v) : (rs1_v + rs2_v);
      exp_wr    = 1'b1;
      idx_bad   = idx_oob(rs1) | idx_oob(rs2) | idx_oob(rd);
    end else if (is_addi) begin
      exp_wdata = rs1_v + imm_i;
      exp_wr    = 1'b1;
      idx_bad   = idx_oob(rs1) | idx_oob(rd);
    end else if (is_beq || is_bne) begin
      if ((rs1_v == rs2_v) == is_beq) exp_npc = retire_pc + imm_b;
      idx_bad   = idx_oob(rs1) | idx_oob(rs2);
    end else if (is_jal) begin
      exp_wdata = pc_plus4;
      exp_npc   = retire_pc + imm_j;
      exp_wr    = 1'b1;
      idx_bad   = idx_oob(rd);
    end else begin
      is_chk    = 1'b0;
    end

    // Writes to x0 are architectural no-ops on both sides.
    exp_we  = exp_wr && (rd != 5'd0);
    core_we = rf_we && (rf_waddr != 5'd0);
    wr_mis  = (exp_we != core_we) || (exp_we && core_we && (rf_waddr != rd));
    wd_mis  = exp_we && core_we && (rf_waddr == rd) && (rf_wdata != exp_wdata);
    npc_mis = (retire_next_pc != exp_npc);

    if (idx_bad)      code_now = 3'd4;
    else if (wd_mis)  code_now = 3'd1;
    else if (wr_mis)  code_now = 3'd2;
    else if (npc_mis) code_now = 3'd3;
    else              code_now = 3'd0;

    do_chk  = in_check && retire_valid && is_chk;
    err_hit = do_chk && (code_now != 3'd0);
  end

  // Shadow file follows every core write, in every FSM state
  always_comb begin
    shadow_d = shadow_q;
    if (retire_valid && rf_we && (rf_waddr != 5'd0) && !idx_oob(rf_waddr))
      shadow_d[rf_waddr[AW-1:0]] = rf_wdata;
  end

  // Shadow register storage, zeroed by reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Next FSM state: errors halt only when configured to stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (chk_en) state_d = S_CHECK;
      S_CHECK: begin
        if (err_hit && (STOP_ON_ERR != 0)) state_d = S_HALT;
        else if (!chk_en)                  state_d = S_IDLE;
      end
      S_HALT:  if (err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered chk_active
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      chk_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chk_active_q <= (state_d == S_CHECK);
    end
  end

  // Sticky error, first-error capture and counters; a new error beats err_clr
  always_comb begin
    chk_error_d     = err_clr ? 1'b0 : chk_error_q;
    err_code_d      = err_clr ? 3'd0 : err_code_q;
    err_pc_d        = err_clr ? '0   : err_pc_q;
    err_instr_d     = err_clr ? '0   : err_instr_q;
    err_count_d     = err_clr ? '0   : err_count_q;
    retired_count_d = err_clr ? '0   : retired_count_q;
    if (err_hit) begin
      chk_error_d = 1'b1;
      err_count_d = sat_inc(err_count_d);
      if (!chk_error_q || err_clr) begin
        err_code_d  = code_now;
        err_pc_d    = retire_pc;
        err_instr_d = retire_instr;
      end
    end
    if (in_check && retire_valid) retired_count_d = sat_inc(retired_count_d);
  end

  // Error/capture/counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chk_error_q     <= 1'b0;
      err_code_q      <= 3'd0;
      err_pc_q        <= '0;
      err_instr_q     <= '0;
      err_count_q     <= '0;
      retired_count_q <= '0;
    end else begin
      chk_error_q     <= chk_error_d;
      err_code_q      <= err_code_d;
      err_pc_q        <= err_pc_d;
      err_instr_q     <= err_instr_d;
      err_count_q     <= err_count_d;
      retired_count_q <= retired_count_d;
    end
  end

`ifdef ISA_RETIRE_CHK_COVER_EN
  logic [4:0] cov_q, cov_d;

  // Sticky class coverage; a retire in the clearing cycle still sets its bit
  always_comb begin
    cov_d = err_clr ? 5'd0 : cov_q;
    if (in_check && retire_valid) begin
      if (is_add)            cov_d[0] = 1'b1;
      if (is_sub)            cov_d[1] = 1'b1;
      if (is_addi)           cov_d[2] = 1'b1;
      if (is_beq || is_bne)  cov_d[3] = 1'b1;
      if (is_jal)            cov_d[4] = 1'b1;
    end
  end

  // Coverage register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cov_q <= 5'd0;
    else         cov_q <= cov_d;
  end

  assign cov_seen = cov_q;
`else
  assign cov_seen = 5'd0;
`endif

  assign chk_active    = chk_active_q;
  assign chk_error     = chk_error_q;
  assign err_code      = err_code_q;
  assign err_pc        = err_pc_q;
  assign err_instr     = err_instr_q;
  assign err_count     = err_count_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_isa_retire_checker.sv
// Directed bench for isa_retire_checker: default instance, STOP_ON_ERR=1
// instance and CNT_W=2 instance, all sharing one retire stream.
module tb_isa_retire_checker;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        retire_valid;
  logic [31:0] retire_pc, retire_instr, retire_next_pc, rf_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        chk_en_0, chk_en_1, chk_en_2;
  logic        err_clr_0, err_clr_1, err_clr_2;

  logic        act_0, act_1, act_2;
  logic        err_0, err_1, err_2;
  logic [2:0]  code_0, code_1, code_2;
  logic [31:0] epc_0, epc_1, epc_2;
  logic [31:0] eins_0, eins_1, eins_2;
  logic [15:0] ecnt_0, ecnt_1, rcnt_0, rcnt_1;
  logic [1:0]  ecnt_2, rcnt_2;
  logic [4:0]  cov_0, cov_1, cov_2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  isa_retire_checker u0 (
    .clk(clk), .arst_n(arst_n), .chk_en(chk_en_0), .err_clr(err_clr_0),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_next_pc(retire_next_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_active(act_0), .chk_error(err_0), .err_code(code_0), .err_pc(epc_0),
    .err_instr(eins_0), .err_count(ecnt_0), .retired_count(rcnt_0), .cov_seen(cov_0)
  );

  isa_retire_checker #(.STOP_ON_ERR(1)) u1 (
    .clk(clk), .arst_n(arst_n), .chk_en(chk_en_1), .err_clr(err_clr_1),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_next_pc(retire_next_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_active(act_1), .chk_error(err_1), .err_code(code_1), .err_pc(epc_1),
    .err_instr(eins_1), .err_count(ecnt_1), .retired_count(rcnt_1), .cov_seen(cov_1)
  );

  isa_retire_checker #(.CNT_W(2)) u2 (
    .clk(clk), .arst_n(arst_n), .chk_en(chk_en_2), .err_clr(err_clr_2),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_next_pc(retire_next_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_active(act_2), .chk_error(err_2), .err_code(code_2), .err_pc(epc_2),
    .err_instr(eins_2), .err_count(ecnt_2), .retired_count(rcnt_2), .cov_seen(cov_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One retire cycle; outputs are sampled 1 ns after the capturing edge.
  task automatic ret(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] npc,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    retire_valid   = 1'b1;
    retire_pc      = pc;
    retire_instr   = ins;
    retire_next_pc = npc;
    rf_we          = we;
    rf_waddr       = wa;
    rf_wdata       = wd;
    tick();
    retire_valid = 1'b0;
    rf_we        = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    retire_valid = 1'b0; retire_pc = '0; retire_instr = '0; retire_next_pc = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    chk_en_0 = 1'b0; chk_en_1 = 1'b0; chk_en_2 = 1'b0;
    err_clr_0 = 1'b0; err_clr_1 = 1'b0; err_clr_2 = 1'b0;

    #12;
    chk("rst_active", 32'(act_0), 0);
    chk("rst_error",  32'(err_0), 0);
    chk("rst_code",   32'(code_0), 0);
    chk("rst_pc",     epc_0, 0);
    chk("rst_ecnt",   32'(ecnt_0), 0);
    chk("rst_rcnt",   32'(rcnt_0), 0);
    chk("rst_cov",    32'(cov_0), 0);
    arst_n = 1'b1;

    chk_en_0 = 1'b1;
    tick();
    chk("active_after_en", 32'(act_0), 1);

    ret(32'h0, 32'h00500093, 32'h4, 1'b1, 5'd1, 32'd5);          // ADDI x1,x0,5
    chk("addi_err", 32'(err_0), 0);
    chk("addi_rcnt", 32'(rcnt_0), 1);

    ret(32'h4, 32'h00700113, 32'h8, 1'b1, 5'd2, 32'd7);          // ADDI x2,x0,7
    chk("addi2_rcnt", 32'(rcnt_0), 2);

    ret(32'h8, 32'h002081B3, 32'hC, 1'b1, 5'd3, 32'd11);         // ADD x3,x1,x2 -> 12
    chk("add_bad_err",  32'(err_0), 1);
    chk("add_bad_code", 32'(code_0), 1);
    chk("add_bad_pc",   epc_0, 32'h8);
    chk("add_bad_ins",  eins_0, 32'h002081B3);
    chk("add_bad_ecnt", 32'(ecnt_0), 1);

    err_clr_0 = 1'b1; tick(); err_clr_0 = 1'b0;
    chk("clr_err",  32'(err_0), 0);
    chk("clr_code", 32'(code_0), 0);
    chk("clr_pc",   epc_0, 0);
    chk("clr_ecnt", 32'(ecnt_0), 0);
    chk("clr_rcnt", 32'(rcnt_0), 0);

    ret(32'h20, 32'h00108863, 32'h24, 1'b0, 5'd0, 32'd0);        // BEQ taken, wrong npc
    chk("beq_bad_code", 32'(code_0), 3);
    chk("beq_bad_pc",   epc_0, 32'h20);

    err_clr_0 = 1'b1; tick(); err_clr_0 = 1'b0;
    ret(32'h20, 32'h00108863, 32'h30, 1'b0, 5'd0, 32'd0);        // BEQ taken, right npc
    chk("beq_ok_err",  32'(err_0), 0);
    chk("beq_ok_rcnt", 32'(rcnt_0), 1);

    ret(32'h40, 32'h008000EF, 32'h48, 1'b1, 5'd1, 32'h44);       // JAL x1,+8
    chk("jal_err", 32'(err_0), 0);

    ret(32'h48, 32'h402081B3, 32'h4C, 1'b1, 5'd3, 32'h3D);       // SUB x3,x1,x2 after JAL
    chk("sub_hazard_err", 32'(err_0), 0);

    ret(32'h4C, 32'h00308013, 32'h50, 1'b0, 5'd0, 32'd0);        // ADDI x0,x1,3 no write
    chk("addi_x0_err", 32'(err_0), 0);

    ret(32'h50, 32'h002082B3, 32'h54, 1'b1, 5'd5, 32'h4B);       // ADD x5,x1,x2
    chk("add_ok_err",  32'(err_0), 0);
    chk("add_ok_rcnt", 32'(rcnt_0), 5);
`ifdef ISA_RETIRE_CHK_COVER_EN
    chk("cov_all", 32'(cov_0), 32'h1F);
`else
    chk("cov_off", 32'(cov_0), 0);
`endif

    ret(32'h60, 32'h00209463, 32'h64, 1'b1, 5'd5, 32'h99);       // BNE spurious write + bad npc
    chk("bne_code", 32'(code_0), 2);
    chk("bne_pc",   epc_0, 32'h60);
    chk("bne_ecnt", 32'(ecnt_0), 1);
    chk("bne_rcnt", 32'(rcnt_0), 6);

    err_clr_0 = 1'b1;
    ret(32'h70, 32'h002081B3, 32'h74, 1'b1, 5'd3, 32'h0);        // clear + new error
    err_clr_0 = 1'b0;
    chk("clrnew_err",  32'(err_0), 1);
    chk("clrnew_code", 32'(code_0), 1);
    chk("clrnew_pc",   epc_0, 32'h70);
    chk("clrnew_ecnt", 32'(ecnt_0), 1);
    chk("clrnew_rcnt", 32'(rcnt_0), 1);

    ret(32'h80, 32'h00308013, 32'h88, 1'b0, 5'd0, 32'd0);        // second error, capture holds
    chk("second_ecnt", 32'(ecnt_0), 2);
    chk("second_code", 32'(code_0), 1);
    chk("second_pc",   epc_0, 32'h70);
`ifdef ISA_RETIRE_CHK_COVER_EN
    chk("cov_after_clr", 32'(cov_0), 32'h05);
`else
    chk("cov_off2", 32'(cov_0), 0);
`endif

    chk_en_0 = 1'b0; tick();
    chk("idle_active", 32'(act_0), 0);
    ret(32'h90, 32'h00308013, 32'h98, 1'b0, 5'd0, 32'd0);
    chk("idle_ecnt", 32'(ecnt_0), 2);
    chk("idle_rcnt", 32'(rcnt_0), 2);

    // STOP_ON_ERR instance: x1=0x44, x2=7 so ADD x3 expects 0x4B
    chk_en_1 = 1'b1; tick();
    chk("stop_active", 32'(act_1), 1);
    for (int i = 0; i < 4; i++) ret(32'h100, 32'h002081B3, 32'h104, 1'b1, 5'd3, 32'h0);
    chk("stop_ecnt",   32'(ecnt_1), 1);
    chk("stop_active_halt", 32'(act_1), 0);
    chk("stop_err",    32'(err_1), 1);
    chk("stop_rcnt",   32'(rcnt_1), 1);
    err_clr_1 = 1'b1; chk_en_1 = 1'b0; tick(); err_clr_1 = 1'b0;
    chk("stop_clr_err",  32'(err_1), 0);
    chk("stop_clr_ecnt", 32'(ecnt_1), 0);
    tick();
    chk("stop_idle_active", 32'(act_1), 0);

    // CNT_W=2 instance saturates at 3
    chk_en_2 = 1'b1; tick();
    for (int i = 0; i < 5; i++) ret(32'h200, 32'h002081B3, 32'h204, 1'b1, 5'd3, 32'h0);
    chk("sat_ecnt", 32'(ecnt_2), 3);
    chk("sat_rcnt", 32'(rcnt_2), 3);
    chk("sat_err",  32'(err_2), 1);

    // Asynchronous reset away from any clock edge
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_ecnt0", 32'(ecnt_0), 0);
    chk("arst_err0",  32'(err_0), 0);
    chk("arst_pc0",   epc_0, 0);
    chk("arst_ecnt2", 32'(ecnt_2), 0);
    chk("arst_act2",  32'(act_2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/isa_retire_checker.md
# isa_retire_checker

Synthesizable, parametrised retirement checker for the RV32 Fibonacci core. It sits beside `microprocessor_top` and observes the retire stream: PC, instruction, register-file write and next PC. For each retired ADD, SUB, ADDI, BEQ, BNE or JAL, it computes the architecturally expected result from a private shadow register file and flags any mismatch. It turns our formal ADD/ADDI/BEQ/JAL properties into an always-on runtime monitor with first-error capture, error counting and an optional halt.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `NREGS`, 32: architectural registers (16 for RV32E); must be a power of two.
- `CNT_W`, 16: width of the error and retire counters.
- `STOP_ON_ERR`, 0: if 1, the first error halts checking.

Ports:
- `clk`, in, 1: clock; the single clock domain.
- `arst_n`, in, 1: reset; asynchronous, active-low.
- `chk_en`, in, 1: checking enable.
- `err_clr`, in, 1: clears the sticky error state and counters.
- `retire_valid`, in, 1: one instruction retires this cycle.
- `retire_pc`, in, XLEN: PC of the retiring instruction.
- `retire_instr`, in, 32: instruction word.
- `retire_next_pc`, in, XLEN: PC the core fetches next.
- `rf_we`, in, 1: core register-file write enable.
- `rf_waddr`, in, 5: core write address.
- `rf_wdata`, in, XLEN: core write data.
- `chk_active`, out, 1: FSM is in CHECK.
- `chk_error`, out, 1: sticky error flag.
- `err_code`, out, 3: code of the first error.
- `err_pc`, out, XLEN: PC of the first error.
- `err_instr`, out, 32: instruction word of the first error.
- `err_count`, out, CNT_W: saturating error count.
- `retired_count`, out, CNT_W: saturating count of instructions checked.
- `cov_seen`, out, 5: instruction-class coverage (see Configuration).

## Operation
- **Shadow register file:** `NREGS`×`XLEN`, zero at reset; x0 reads 0.
  - Written from `rf_wdata` whenever `retire_valid & rf_we & rf_waddr!=0`, in every FSM state. Tracking the core's writes keeps a single error from cascading.
- **FSM states:** IDLE, CHECK, HALT; reset state is IDLE.
  - IDLE→CHECK when `chk_en=1`.
  - CHECK→IDLE when `chk_en=0`.
  - CHECK→HALT on any error when `STOP_ON_ERR=1`.
  - HALT→IDLE on `err_clr`.
- **Expected results:** computed only in CHECK with `retire_valid`, from shadow values read before this cycle's write.
  - ADD (funct7=0, funct3=0), SUB (funct7=0x20): rd = rs1 ± rs2, next PC = pc+4.
  - ADDI: rd = rs1 + sext(imm[11:0]), next PC = pc+4.
  - BEQ, BNE: no write; next PC = pc + sext(imm13) if taken, else pc+4.
  - JAL: rd = pc+4, next PC = pc + sext(imm21).
  - Arithmetic is modulo 2^XLEN.
  - Other opcodes are not checked but still counted in `retired_count`.
- **Error codes:** when several conditions apply, the lowest code is recorded.
  - 1: wdata mismatch.
  - 2: write mismatch, i.e. missing write, spurious write, or wrong `rf_waddr` (rd=0 never requires a write, and a write to x0 is ignored).
  - 3: next-PC mismatch.
  - 4: rs1, rs2 or rd index ≥ `NREGS`; the other comparisons are skipped.
- **First-error capture:** `err_code`, `err_pc` and `err_instr` are loaded only while `chk_error=0`. They hold until `err_clr`.
- **Counters:** `err_count` and `retired_count` saturate at 2^CNT_W−1 and never change in IDLE or HALT.

## Timing
- **Reset values:** every output is 0, the FSM is in IDLE and the shadow file is zeroed. Reset mid-operation has the same effect immediately (asynchronously).
- **Comparison latency:** comparison is combinational in the retire cycle. `chk_error`, capture registers and counters update at the next clock edge, i.e. one-cycle latency.
- **`chk_active`:** registered; high from the first cycle after the IDLE→CHECK transition.
- **`err_clr` together with a new error:** the new error wins. Result is `chk_error=1`, `err_count=1` and the new error captured.
- **`err_clr` alone:** clears `chk_error`, `err_code`, `err_pc`, `err_instr`, `err_count` and `retired_count`. The shadow file is untouched.
- **Write-then-read hazard:** a write and a dependent instruction in consecutive retire cycles see the updated shadow value; the shadow write completes at the edge.

## Configuration
- **`ISA_RETIRE_CHK_COVER_EN` defined:** `cov_seen` holds sticky bits, set in CHECK on retire.
  - [0] ADD, [1] SUB, [2] ADDI, [3] BEQ/BNE, [4] JAL.
  - Cleared by `err_clr` and reset.
- **Not defined:** `cov_seen` is tied to 0 and no coverage logic is generated.

## Test plan
- Reset, `chk_en=1`, ADDI x1,x0,5 (0x00500093) at pc 0, core writes x1=5, next_pc 4 → `chk_error=0`, `retired_count=1`.
- With x1=5 and x2=7 in the shadow file, ADD x3,x1,x2 where the core writes 11 → next cycle `chk_error=1`, `err_code=1`, `err_pc=retire_pc`, `err_count=1`.
- BEQ x1,x1,+16 at pc 0x20 with core next_pc 0x24 → `err_code=3`. A repeat with next_pc 0x30 and the error cleared → no error.
- JAL x1,+8 at pc 0x40 with wdata 0x44 and next_pc 0x48 → no error. ADDI x0,x1,3 with `rf_we=0` → no error.
- `STOP_ON_ERR=1`: one bad ADD, then 3 more bad ones → `err_count=1`, `chk_active=0`. Then `err_clr` → `chk_error=0`, FSM in IDLE.
- `CNT_W=2`, 5 consecutive bad retires → `err_count=3`. With `ISA_RETIRE_CHK_COVER_EN` defined, after ADD, SUB, ADDI, BEQ and JAL → `cov_seen=5'b11111`.
